// File: rtl/wb_sim_pkg.sv
// Shared types and constants for the Wishbone simulation slave/master models.
package wb_sim_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_state_e;

   localparam int          LFSR_W    = 16;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] DEF_SEED  = 16'hACE1;

   localparam int DAT_W = 32;
   localparam int ADR_W = 30;
   localparam int SEL_W = 4;

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic             we;
      logic [SEL_W-1:0] sel;
      logic [DAT_W-1:0] dat;
   } wb_req_t;

   // Expands byte-lane selects to a per-bit data mask.
   function automatic logic [DAT_W-1:0] sel_mask(input logic [SEL_W-1:0] s);
      logic [DAT_W-1:0] m;
      for (int i = 0; i < SEL_W; i++) m[8*i +: 8] = {8{s[i]}};
      return m;
   endfunction

   // Seed perturbed by slave id; an all-zero state would lock the LFSR.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      return (s == '0) ? DEF_SEED : s;
   endfunction
endpackage

// File: rtl/wb_lfsr16.sv
// 16-bit Galois LFSR (right shift, taps LFSR_TAPS); steps on adv, reloads seed on reset.
module wb_lfsr16
   import wb_sim_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              adv,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state <= seed;
      else if (adv)
         state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
   end
endmodule

// File: rtl/wb_slave_responder.sv
// Wishbone classic slave: RAM window with LFSR-driven wait states and transfer counters.
// Optional WB_SLAVE_RESPONDER_ERR_EN: out-of-window accesses terminate with err instead of ack.
module wb_slave_responder
   import wb_sim_pkg::*;
#(
   parameter int          id      = 0,
   parameter int          aw      = 8,
   parameter logic [29:0] base    = 30'h0,
   parameter logic [3:0]  ws_mask = 4'h3,
   parameter logic [15:0] seed    = 16'hACE1,
   parameter int          nreads  = 10,
   parameter int          nwrites = 10
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [DAT_W-1:0] dat_w,
   output logic [DAT_W-1:0] dat_r,
   input  logic [ADR_W-1:0] adr,
   input  logic             we,
   input  logic [SEL_W-1:0] sel,
   input  logic             cyc,
   input  logic             stb,
   output logic             ack,
   output logic             err,
   output logic [15:0]      rcount,
   output logic [15:0]      wcount,
   output logic             tend
);
   localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(seed ^ 16'(id));

   wb_state_e         state, state_nxt;
   logic [3:0]        wcnt, wcnt_nxt, w_new;
   logic [LFSR_W-1:0] lfsr;
   logic              accept, go_ack, hit, fin_ok, cnt_en, do_wr;
   logic [aw-1:0]     idx;
   logic [DAT_W-1:0]  lane_m;
   wb_req_t           req;
   logic [DAT_W-1:0]  mem [2**aw];
   logic              unused_lfsr;

   assign req    = '{adr: adr, we: we, sel: sel, dat: dat_w};
   assign hit    = (req.adr[ADR_W-1:aw] == base[ADR_W-1:aw]);
   assign idx    = req.adr[aw-1:0];
   assign lane_m = sel_mask(req.sel);
   assign accept = (state == IDLE) && cyc && stb;
   assign w_new  = lfsr[3:0] & ws_mask;
   assign unused_lfsr = ^lfsr[LFSR_W-1:4];

   wb_lfsr16 u_lfsr (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .adv       (accept),
      .seed      (SEED_EFF),
      .state     (lfsr)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         IDLE: if (cyc && stb) begin
            if (w_new == 4'd0) state_nxt = ACK;
            else begin
               state_nxt = WAIT;
               wcnt_nxt  = w_new;
            end
         end
         WAIT: begin
            if (!(cyc && stb))      state_nxt = IDLE;
            else if (wcnt == 4'd1)  state_nxt = ACK;
            else                    wcnt_nxt  = wcnt - 4'd1;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // All side effects happen on the edge that enters ACK, using the bus sampled there.
   assign go_ack = (state_nxt == ACK);
`ifdef WB_SLAVE_RESPONDER_ERR_EN
   assign fin_ok = hit;
`else
   assign fin_ok = 1'b1;
`endif
   assign cnt_en = go_ack && fin_ok;
   assign do_wr  = go_ack && req.we && hit && sys_rst_n;

   always_ff @(posedge sys_clk) begin
      for (int i = 0; i < SEL_W; i++)
         if (do_wr && req.sel[i]) mem[idx][8*i +: 8] <= req.dat[8*i +: 8];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ack    <= 1'b0;
         dat_r  <= '0;
         rcount <= '0;
         wcount <= '0;
         tend   <= 1'b0;
      end else begin
         ack  <= cnt_en;
         tend <= (rcount >= 16'(nreads)) && (wcount >= 16'(nwrites));
         if (cnt_en && !req.we) dat_r <= hit ? (mem[idx] & lane_m) : '0;
         if (cnt_en && !req.we && rcount != 16'hFFFF) rcount <= rcount + 16'd1;
         if (cnt_en &&  req.we && wcount != 16'hFFFF) wcount <= wcount + 16'd1;
      end
   end

`ifdef WB_SLAVE_RESPONDER_ERR_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) err <= 1'b0;
      else            err <= go_ack && !hit;
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_slave_responder.sv
// Bench for wb_slave_responder: directed vector table, random latency scoreboard, abort/miss/reset sequences.
module tb_wb_slave_responder;
   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [31:0] dat_w = '0;
   logic [29:0] adr = '0;
   logic        we = 1'b0;
   logic [3:0]  sel = '0;
   logic        stb = 1'b0;
   logic [1:0]  cyc = '0;
   logic [1:0]  ack_v, err_v, tend_v;
   logic [31:0] dat_v [2];
   logic [15:0] rc_v [2];
   logic [15:0] wc_v [2];

   always #5 sys_clk = ~sys_clk;

   wb_slave_responder #(.id(0), .aw(8), .base(30'h0), .ws_mask(4'h0), .seed(16'hACE1),
                        .nreads(2), .nwrites(2)) u0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dat_w(dat_w), .dat_r(dat_v[0]), .adr(adr),
      .we(we), .sel(sel), .cyc(cyc[0]), .stb(stb), .ack(ack_v[0]), .err(err_v[0]),
      .rcount(rc_v[0]), .wcount(wc_v[0]), .tend(tend_v[0]));

   wb_slave_responder #(.id(2), .aw(8), .base(30'h0), .ws_mask(4'hF), .seed(16'hACE1),
                        .nreads(10), .nwrites(10)) u1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dat_w(dat_w), .dat_r(dat_v[1]), .adr(adr),
      .we(we), .sel(sel), .cyc(cyc[1]), .stb(stb), .ack(ack_v[1]), .err(err_v[1]),
      .rcount(rc_v[1]), .wcount(wc_v[1]), .tend(tend_v[1]));

   typedef struct {
      bit          is_err;
      bit          chk_dat;
      logic [31:0] dat;
      int          lat;
   } exp_t;

   typedef struct {
      bit          w;
      logic [29:0] a;
      logic [3:0]  s;
      logic [31:0] dw;
      logic [31:0] rd;
      logic [15:0] rc;
      logic [15:0] wc;
   } vec_t;

   exp_t        sbq[$];
   logic [15:0] m_lfsr [2];
   logic [3:0]  m_mask [2];
   logic [31:0] m_last [2];
   logic [31:0] mem1 [16];
   int          tests = 0, fails = 0, dbl = 0;
   bit          pend_hold = 0, tend_at_term = 0;
   logic [1:0]  prev_ack = '0;

   always @(negedge sys_clk) begin
      for (int d = 0; d < 2; d++) if (ack_v[d] && prev_ack[d]) dbl++;
      prev_ack <= ack_v;
   end

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{s[l]}};
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lfsr[0] = 16'hACE1;
      m_lfsr[1] = 16'hACE1 ^ 16'h0002;
      m_last[0] = '0;
      m_last[1] = '0;
   endtask

   task automatic xfer(input int d, input bit w, input logic [29:0] a, input logic [3:0] s,
                       input logic [31:0] dw, input logic [31:0] rd, input bit hold, input bit miss);
      exp_t e;
      int   lat;
      bit   got_err;
      bit   prev_hold;
      prev_hold = pend_hold;
      cyc = '0; cyc[d] = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = dw;
      e.lat = 1 + int'(m_lfsr[d][3:0] & m_mask[d]);
      m_lfsr[d] = lfsr_step(m_lfsr[d]);
`ifdef WB_SLAVE_RESPONDER_ERR_EN
      e.is_err = miss;
`else
      e.is_err = 1'b0;
`endif
      e.chk_dat = !(w && miss);
      if (!w && !e.is_err) m_last[d] = miss ? 32'h0 : rd;
      e.dat = m_last[d];
      sbq.push_back(e);
      if (prev_hold) begin
         @(posedge sys_clk); #1;
         chk("no_b2b_term", {ack_v[d], err_v[d]}, 32'h0);
      end
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge sys_clk); #1;
         if (ack_v[d] || err_v[d]) begin lat = n; break; end
      end
      got_err = err_v[d];
      tend_at_term = tend_v[d];
      if (!hold || lat == 0) begin cyc = '0; stb = 1'b0; end
      pend_hold = hold && (lat != 0);
      e = sbq.pop_front();
      if (lat == 0) begin
         tests++; fails++;
         $display("FAIL xfer_timeout: no termination within 40 cycles, expected latency %0d", e.lat);
      end else begin
         chk("latency", lat, e.lat);
         chk("term_err", got_err, e.is_err);
         chk("term_ack", ack_v[d], !e.is_err);
         if (e.chk_dat) chk("dat_r", dat_v[d], e.dat);
      end
      if (!pend_hold) begin
         @(posedge sys_clk); #1;
         chk("one_cycle", {ack_v[d], err_v[d]}, 32'h0);
      end
   endtask

   task automatic wait_long_ws();
      while ((m_lfsr[1][3:0] & m_mask[1]) < 4'd3) xfer(1, 0, 30'd0, 4'hF, 32'h0, mem1[0], 0, 0);
   endtask

   initial begin
      vec_t        tbl [6];
      int          nr, nw, acks;
      logic [15:0] rc0, wc0;
      logic [31:0] v, d32;
      logic [29:0] a;
      logic [3:0]  s;
      bit          w, hold;

      tbl[0] = '{1, 30'd0, 4'hF,    32'hDEADBEEF, 32'h0,        16'd0, 16'd1};
      tbl[1] = '{0, 30'd0, 4'hF,    32'h0,        32'hDEADBEEF, 16'd1, 16'd1};
      tbl[2] = '{1, 30'd1, 4'hF,    32'hFFFFFFFF, 32'h0,        16'd1, 16'd2};
      tbl[3] = '{1, 30'd1, 4'b0101, 32'h00000000, 32'h0,        16'd1, 16'd3};
      tbl[4] = '{0, 30'd1, 4'hF,    32'h0,        32'hFF00FF00, 16'd2, 16'd3};
      tbl[5] = '{0, 30'd1, 4'b0011, 32'h0,        32'h0000FF00, 16'd3, 16'd3};
      m_mask[0] = 4'h0;
      m_mask[1] = 4'hF;
      model_reset();

      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ack", ack_v[d], 0);
         chk("rst_err", err_v[d], 0);
         chk("rst_dat_r", dat_v[d], 0);
         chk("rst_rcount", rc_v[d], 0);
         chk("rst_wcount", wc_v[d], 0);
         chk("rst_tend", tend_v[d], 0);
      end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      for (int i = 0; i < 6; i++) begin
         xfer(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].dw, tbl[i].rd, 0, 0);
         chk("vec_rcount", rc_v[0], tbl[i].rc);
         chk("vec_wcount", wc_v[0], tbl[i].wc);
      end

      xfer(0, 1, 30'h100, 4'hF, 32'h12345678, 32'h0, 0, 1);
      xfer(0, 0, 30'h000, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
      xfer(0, 0, 30'h100, 4'hF, 32'h0, 32'h0, 0, 1);
`ifdef WB_SLAVE_RESPONDER_ERR_EN
      chk("miss_rcount", rc_v[0], 16'd4);
      chk("miss_wcount", wc_v[0], 16'd3);
`else
      chk("miss_rcount", rc_v[0], 16'd5);
      chk("miss_wcount", wc_v[0], 16'd4);
`endif

      nr = 0; nw = 0;
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         mem1[i] = v;
         xfer(1, 1, 30'(i), 4'hF, v, 32'h0, 0, 0);
         nw++;
      end
      for (int i = 0; i < 200; i++) begin
         w    = 1'($urandom_range(0, 1));
         a    = 30'($urandom_range(0, 15));
         s    = 4'($urandom);
         d32  = $urandom;
         hold = (i < 199) && ($urandom_range(0, 3) == 0);
         v    = mem1[a[3:0]] & lane_mask(s);
         xfer(1, w, a, s, d32, v, hold, 0);
         if (w) begin
            for (int l = 0; l < 4; l++) if (s[l]) mem1[a[3:0]][8*l +: 8] = d32[8*l +: 8];
            nw++;
         end else nr++;
      end
      chk("rand_rcount", rc_v[1], 16'(nr));
      chk("rand_wcount", wc_v[1], 16'(nw));

      wait_long_ws();
      rc0 = rc_v[1]; wc0 = wc_v[1];
      cyc = 2'b10; stb = 1'b1; we = 1'b1; adr = 30'd5; sel = 4'hF; dat_w = ~mem1[5];
      m_lfsr[1] = lfsr_step(m_lfsr[1]);
      acks = 0;
      repeat (2) begin @(posedge sys_clk); #1; acks += int'(ack_v[1] | err_v[1]); end
      cyc = '0; stb = 1'b0;
      repeat (6) begin @(posedge sys_clk); #1; acks += int'(ack_v[1] | err_v[1]); end
      chk("abort_no_ack", acks, 0);
      chk("abort_rcount", rc_v[1], rc0);
      chk("abort_wcount", wc_v[1], wc0);
      xfer(1, 0, 30'd5, 4'hF, 32'h0, mem1[5], 0, 0);

      wait_long_ws();
      cyc = 2'b10; stb = 1'b1; we = 1'b1; adr = 30'd6; sel = 4'hF; dat_w = ~mem1[6];
      @(posedge sys_clk); #3;
      sys_rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("midrst_ack", ack_v[d], 0);
         chk("midrst_err", err_v[d], 0);
         chk("midrst_rcount", rc_v[d], 0);
         chk("midrst_wcount", wc_v[d], 0);
         chk("midrst_tend", tend_v[d], 0);
      end
      cyc = '0; stb = 1'b0;
      model_reset();
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      xfer(1, 0, 30'd6, 4'hF, 32'h0, mem1[6], 0, 0);

      xfer(0, 1, 30'd2, 4'hF, 32'hA5A5A5A5, 32'h0, 0, 0);
      xfer(0, 1, 30'd3, 4'hF, 32'h3C3C3C3C, 32'h0, 0, 0);
      chk("tend_w2", tend_v[0], 0);
      xfer(0, 0, 30'd2, 4'hF, 32'h0, 32'hA5A5A5A5, 0, 0);
      chk("tend_r1", tend_v[0], 0);
      xfer(0, 0, 30'd3, 4'hF, 32'h0, 32'h3C3C3C3C, 0, 0);
      chk("tend_at_ack", tend_at_term, 0);
      chk("tend_rise", tend_v[0], 1);

      chk("no_consecutive_ack", dbl, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
